// File: rtl/palu_pkg.sv
// Shared constants for the PALU operand sequencer: FSM encoding, button indices, widths.
package palu_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned OP_W    = 2;
  localparam int unsigned NUM_BTN = 4;

  localparam int unsigned BTN_LOAD_A = 0;
  localparam int unsigned BTN_LOAD_B = 1;
  localparam int unsigned BTN_EXEC   = 2;
  localparam int unsigned BTN_CLEAR  = 3;

  typedef enum logic [1:0] {
    WAIT_A  = 2'b00,
    WAIT_B  = 2'b01,
    READY   = 2'b10,
    CAPTURE = 2'b11
  } state_e;

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchronizer, stability counter, and a one-cycle pulse on
// each debounced rising edge.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_pulse
);

  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;
  logic             pulse_q;
  logic             pulse_d;

  // Counter only advances while the synchronized input disagrees with the level;
  // any agreement (a bounce back) restarts it from zero.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    pulse_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
        pulse_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign btn_level = level_q;
  assign btn_pulse = pulse_q;

endmodule

// File: rtl/palu_operand_seq.sv
// Operand sequencer for the 8-bit programmable ALU: debounced buttons load A,
// then B/opcode, execute captures the ALU result into a register for the LEDs.
module palu_operand_seq
  import palu_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sw_data,
  input  logic [OP_W-1:0]   op_sel_in,
  input  logic [NUM_BTN-1:0] btn,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_s,
  input  logic [DATA_W-1:0] alu_f,
  input  logic              alu_ovf,
  output logic [DATA_W-1:0] result,
  output logic              result_ovf,
  output logic              result_valid,
  output logic [1:0]        state,
  output logic [7:0]        exec_count
);

  logic [NUM_BTN-1:0] pulse;
  logic [NUM_BTN-1:0] unused_btn_level;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_btn_debounce (
      .clk       (clk),
      .rst       (rst),
      .btn_raw   (btn[i]),
      .btn_level (unused_btn_level[i]),
      .btn_pulse (pulse[i])
    );
  end

  state_e            state_q,        state_d;
  logic [DATA_W-1:0] alu_a_q,        alu_a_d;
  logic [DATA_W-1:0] alu_b_q,        alu_b_d;
  logic [OP_W-1:0]   alu_s_q,        alu_s_d;
  logic [DATA_W-1:0] result_q,       result_d;
  logic              result_ovf_q,   result_ovf_d;
  logic              result_valid_q, result_valid_d;
  logic [7:0]        exec_count_q,   exec_count_d;

  logic act_clear, act_exec, act_load_b, act_load_a;

  // Only the highest-priority pulse in a cycle is allowed to act.
  always_comb begin
    act_clear  = pulse[BTN_CLEAR];
    act_exec   = pulse[BTN_EXEC]   & ~pulse[BTN_CLEAR];
    act_load_b = pulse[BTN_LOAD_B] & ~pulse[BTN_EXEC] & ~pulse[BTN_CLEAR];
    act_load_a = pulse[BTN_LOAD_A] & ~pulse[BTN_LOAD_B] & ~pulse[BTN_EXEC]
               & ~pulse[BTN_CLEAR];
  end

  always_comb begin
    state_d        = state_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_s_d        = alu_s_q;
    result_d       = result_q;
    result_ovf_d   = result_ovf_q;
    result_valid_d = result_valid_q;
    exec_count_d   = exec_count_q;

    if (act_clear) begin
      state_d        = WAIT_A;
      alu_a_d        = '0;
      alu_b_d        = '0;
      alu_s_d        = '0;
      result_d       = '0;
      result_ovf_d   = 1'b0;
      result_valid_d = 1'b0;
      exec_count_d   = '0;
    end else begin
      unique case (state_q)
        WAIT_A: begin
          if (act_load_a) begin
            alu_a_d = sw_data;
            state_d = WAIT_B;
          end
        end
        WAIT_B: begin
          if (act_load_b) begin
            alu_b_d = sw_data;
            alu_s_d = op_sel_in;
            state_d = READY;
          end else if (act_load_a) begin
            alu_a_d = sw_data;
          end
        end
        READY: begin
          if (act_exec) begin
            state_d = CAPTURE;
          end else if (act_load_b) begin
            alu_b_d = sw_data;
            alu_s_d = op_sel_in;
          end else if (act_load_a) begin
            alu_a_d = sw_data;
          end
        end
        CAPTURE: begin
          // Operands were frozen for a full cycle, so alu_f has settled.
          result_d       = alu_f;
          result_ovf_d   = alu_ovf;
          result_valid_d = 1'b1;
          exec_count_d   = exec_count_q + 8'd1;
          state_d        = READY;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= WAIT_A;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_s_q        <= '0;
      result_q       <= '0;
      result_ovf_q   <= 1'b0;
      result_valid_q <= 1'b0;
      exec_count_q   <= '0;
    end else begin
      state_q        <= state_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_s_q        <= alu_s_d;
      result_q       <= result_d;
      result_ovf_q   <= result_ovf_d;
      result_valid_q <= result_valid_d;
      exec_count_q   <= exec_count_d;
    end
  end

  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_s        = alu_s_q;
  assign result       = result_q;
  assign result_ovf   = result_ovf_q;
  assign result_valid = result_valid_q;
  assign state        = state_q;
  assign exec_count   = exec_count_q;

endmodule

// File: tb/tb_palu_operand_seq.sv
// Directed bench for palu_operand_seq with a small behavioural ALU as its load.
module tb_palu_operand_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sw_data;
  logic [1:0] op_sel_in;
  logic [3:0] btn;
  logic [7:0] alu_a, alu_b, alu_f, result, exec_count;
  logic [1:0] alu_s, state;
  logic       alu_ovf, result_ovf, result_valid;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  // ALU load: 00 add, 01 sub (signed overflow), 10 and, 11 xor.
  always_comb begin
    logic [7:0] r;
    r       = 8'h00;
    alu_ovf = 1'b0;
    case (alu_s)
      2'b00: begin
        r = alu_a + alu_b;
        alu_ovf = (alu_a[7] == alu_b[7]) && (r[7] != alu_a[7]);
      end
      2'b01: begin
        r = alu_a - alu_b;
        alu_ovf = (alu_a[7] != alu_b[7]) && (r[7] != alu_a[7]);
      end
      2'b10: r = alu_a & alu_b;
      default: r = alu_a ^ alu_b;
    endcase
    alu_f = r;
  end

  palu_operand_seq #(.DEBOUNCE_CYCLES(4), .CNT_W(20)) dut (
    .clk          (clk),
    .rst          (rst),
    .sw_data      (sw_data),
    .op_sel_in    (op_sel_in),
    .btn          (btn),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_s        (alu_s),
    .alu_f        (alu_f),
    .alu_ovf      (alu_ovf),
    .result       (result),
    .result_ovf   (result_ovf),
    .result_valid (result_valid),
    .state        (state),
    .exec_count   (exec_count)
  );

  // Hold the buttons long enough to debounce, then release long enough to settle.
  task automatic press(input logic [3:0] mask);
    btn = mask;
    repeat (10) @(negedge clk);
    btn = 4'b0000;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; btn = 4'b0; sw_data = 8'h00; op_sel_in = 2'b00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (state !== 2'b00) begin tests_failed++; $display("FAIL reset_state got %h exp 00", state); end
    tests_run++;
    if ({alu_a, alu_b, alu_s} !== 18'h0) begin tests_failed++; $display("FAIL reset_operands got %h %h %h exp 0", alu_a, alu_b, alu_s); end
    tests_run++;
    if ({result, result_ovf, result_valid, exec_count} !== 18'h0) begin
      tests_failed++; $display("FAIL reset_result got %h %b %b %h exp 0", result, result_ovf, result_valid, exec_count);
    end
  endtask

  task automatic test_basic();
    sw_data = 8'h05; press(4'b0001);
    tests_run++;
    if (state !== 2'b01 || alu_a !== 8'h05) begin tests_failed++; $display("FAIL load_a got st=%h a=%h exp 01 05", state, alu_a); end
    sw_data = 8'h03; op_sel_in = 2'b00; press(4'b0010);
    tests_run++;
    if (state !== 2'b10 || alu_b !== 8'h03 || alu_s !== 2'b00) begin
      tests_failed++; $display("FAIL load_b got st=%h b=%h s=%h exp 10 03 0", state, alu_b, alu_s);
    end
    // Exec latency: pulse after 2 sync + 4 debounce edges, CAPTURE next, result after that.
    btn = 4'b0100;
    repeat (6) @(negedge clk);
    tests_run++;
    if (state !== 2'b10) begin tests_failed++; $display("FAIL exec_lat_pre got %h exp 10", state); end
    @(negedge clk);
    tests_run++;
    if (state !== 2'b11 || result_valid !== 1'b0) begin
      tests_failed++; $display("FAIL exec_lat_capture got st=%h v=%b exp 11 0", state, result_valid);
    end
    @(negedge clk);
    tests_run++;
    if (state !== 2'b10 || result !== 8'h08 || result_ovf !== 1'b0 || result_valid !== 1'b1 || exec_count !== 8'd1) begin
      tests_failed++; $display("FAIL exec_result got st=%h r=%h o=%b v=%b n=%0d exp 10 08 0 1 1", state, result, result_ovf, result_valid, exec_count);
    end
    repeat (2) @(negedge clk);
    btn = 4'b0000;
    repeat (10) @(negedge clk);
    sw_data = 8'h20; press(4'b0001);
    tests_run++;
    if (alu_a !== 8'h20 || result !== 8'h08 || state !== 2'b10) begin
      tests_failed++; $display("FAIL result_hold got a=%h r=%h st=%h exp 20 08 10", alu_a, result, state);
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 2; i++) begin
      btn = 4'b0100; repeat (2) @(negedge clk);
      btn = 4'b0000; repeat (2) @(negedge clk);
    end
    tests_run++;
    if (exec_count !== 8'd1) begin tests_failed++; $display("FAIL bounce_no_pulse got %0d exp 1", exec_count); end
    btn = 4'b0100; repeat (10) @(negedge clk);
    btn = 4'b0000; repeat (10) @(negedge clk);
    tests_run++;
    if (exec_count !== 8'd2 || result !== 8'h23) begin
      tests_failed++; $display("FAIL bounce_one_exec got n=%0d r=%h exp 2 23", exec_count, result);
    end
  endtask

  task automatic test_wait_a_ignore();
    press(4'b1000);
    sw_data = 8'h44;
    press(4'b0010);
    press(4'b0100);
    tests_run++;
    if (state !== 2'b00 || alu_b !== 8'h00 || result_valid !== 1'b0 || exec_count !== 8'd0) begin
      tests_failed++; $display("FAIL wait_a_ignore got st=%h b=%h v=%b n=%0d exp 00 00 0 0", state, alu_b, result_valid, exec_count);
    end
  endtask

  task automatic test_clear_priority();
    sw_data = 8'h11; press(4'b0001);
    sw_data = 8'h22; op_sel_in = 2'b01; press(4'b0010);
    press(4'b0100);
    tests_run++;
    if (state !== 2'b10 || result !== 8'hEF || exec_count !== 8'd1) begin
      tests_failed++; $display("FAIL sub_result got st=%h r=%h n=%0d exp 10 ef 1", state, result, exec_count);
    end
    press(4'b1100);
    tests_run++;
    if (state !== 2'b00 || {alu_a, alu_b, alu_s} !== 18'h0 || {result, result_ovf, result_valid, exec_count} !== 18'h0) begin
      tests_failed++; $display("FAIL clear_wins got st=%h a=%h b=%h r=%h v=%b n=%0d exp all 0", state, alu_a, alu_b, result, result_valid, exec_count);
    end
  endtask

  task automatic test_wrap();
    int bad;
    bad = 0;
    sw_data = 8'h0F; press(4'b0001);
    sw_data = 8'h33; op_sel_in = 2'b10; press(4'b0010);
    for (int i = 1; i <= 256; i++) begin
      press(4'b0100);
      tests_run++;
      if (result !== 8'h03 || exec_count !== 8'(i)) begin
        tests_failed++;
        if (bad < 4) $display("FAIL wrap_exec%0d got r=%h n=%0d exp 03 %0d", i, result, exec_count, i % 256);
        bad++;
      end
    end
    tests_run++;
    if (exec_count !== 8'd0 || result_valid !== 1'b1 || state !== 2'b10) begin
      tests_failed++; $display("FAIL wrap_end got n=%0d v=%b st=%h exp 0 1 10", exec_count, result_valid, state);
    end
  endtask

  task automatic test_overflow();
    sw_data = 8'h7F; press(4'b0001);
    sw_data = 8'h01; op_sel_in = 2'b00; press(4'b0010);
    press(4'b0100);
    tests_run++;
    if (result !== 8'h80 || result_ovf !== 1'b1 || exec_count !== 8'd1) begin
      tests_failed++; $display("FAIL add_ovf got r=%h o=%b n=%0d exp 80 1 1", result, result_ovf, exec_count);
    end
    press(4'b1000);
    tests_run++;
    if (result !== 8'h00 || result_ovf !== 1'b0 || result_valid !== 1'b0 || state !== 2'b00) begin
      tests_failed++; $display("FAIL ovf_clear got r=%h o=%b v=%b st=%h exp 00 0 0 00", result, result_ovf, result_valid, state);
    end
  endtask

  task automatic test_reset_mid_debounce();
    sw_data = 8'h5A;
    btn = 4'b0001;
    repeat (4) @(negedge clk);
    rst = 1'b1; @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    tests_run++;
    if (state !== 2'b00) begin tests_failed++; $display("FAIL rst_mid_no_pulse got %h exp 00", state); end
    repeat (3) @(negedge clk);
    tests_run++;
    if (state !== 2'b01 || alu_a !== 8'h5A) begin
      tests_failed++; $display("FAIL rst_mid_restable got st=%h a=%h exp 01 5a", state, alu_a);
    end
    btn = 4'b0000;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bounce();
    test_wait_a_ignore();
    test_clear_priority();
    test_wrap();
    test_overflow();
    test_reset_mid_debounce();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
